// File: rtl/macc_pkg.sv
// Shared definitions for the multiply-accumulate group accumulator.
// Holds the default widths, the controller state type and helpers that give
// the signed accumulator limits for a given width.
package macc_pkg;

  localparam int PROD_W_DEF = 15;
  localparam int ACC_W_DEF  = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } macc_state_e;

  // Largest positive value representable in a w-bit signed accumulator.
  function automatic longint ACC_MAX(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Most negative value representable in a w-bit signed accumulator.
  function automatic longint ACC_MIN(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/macc_sat_add.sv
// Combinational ACC_W-bit signed adder with optional saturation.
// Ports:
//   a_i, b_i : signed addends
//   sum_o    : clamped sum (SAT_EN=1) or wrapped sum (SAT_EN=0)
//   ovf_o    : the true sum did not fit in ACC_W signed bits
module macc_sat_add
  import macc_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [ACC_W-1:0] b_i,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    ovf_o
);

  localparam logic signed [ACC_W-1:0] MAX_C = ACC_W'(ACC_MAX(ACC_W));
  localparam logic signed [ACC_W-1:0] MIN_C = ACC_W'(ACC_MIN(ACC_W));

  // One guard bit: the true sum of two ACC_W-bit values always fits in ACC_W+1.
  logic [ACC_W:0] wide;

  assign wide  = {a_i[ACC_W-1], a_i} + {b_i[ACC_W-1], b_i};
  // Overflow when the guard bit disagrees with the result's sign bit.
  assign ovf_o = wide[ACC_W] ^ wide[ACC_W-1];

  always_comb begin
    sum_o = wide[ACC_W-1:0];
    if (SAT_EN && ovf_o) begin
      // Guard bit carries the true sign: negative overflow clamps to MIN.
      sum_o = wide[ACC_W] ? MIN_C : MAX_C;
    end
  end

endmodule

// File: rtl/macc_accumulator.sv
// Dot-product group accumulator. Signed products stream in with a valid/ready
// handshake; in_last closes a group, whose sum, overflow flag and beat count
// are then held on the output side until the consumer takes them.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_prod product, in_last closes group
//   out_valid/out_ready : output handshake
//   out_acc             : signed group sum
//   out_ovf             : saturation/wrap occurred in the group
//   out_count           : beats in the group, saturating at 255
module macc_accumulator
  import macc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic                     out_ovf,
  output logic [7:0]               out_count
);

  macc_state_e             state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              count_q, count_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;
  logic                    in_xfer;
  logic                    grp_start;

  // Size cast of a signed operand sign-extends.
  assign prod_ext = ACC_W'(in_prod);

  macc_sat_add #(
    .ACC_W (ACC_W),
    .SAT_EN(SAT_EN)
  ) u_add (
    .a_i  (acc_q),
    .b_i  (prod_ext),
    .sum_o(sum),
    .ovf_o(add_ovf)
  );

  // In FULL a beat is only accepted while the held result leaves, so any
  // beat outside ACCUM opens a fresh group without a bubble.
  assign in_ready  = (state_q != FULL) || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign grp_start = (state_q != ACCUM);

  assign out_valid = (state_q == FULL);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (in_xfer) begin
      if (grp_start) begin
        acc_d   = prod_ext;
        ovf_d   = 1'b0;
        count_d = 8'd1;
      end else begin
        acc_d   = sum;
        ovf_d   = ovf_q | add_ovf;
        count_d = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
      end
      state_d = in_last ? FULL : ACCUM;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_macc_accumulator.sv
module tb_macc_accumulator;

  localparam int PW = 15;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_last, out_ready;
  logic signed [PW-1:0] in_prod;

  // d: defaults (ACC_W=24, saturating); s: 16-bit saturating; w: 16-bit wrapping
  logic in_ready_d, in_ready_s, in_ready_w;
  logic out_valid_d, out_valid_s, out_valid_w;
  logic out_ovf_d, out_ovf_s, out_ovf_w;
  logic [7:0] out_count_d, out_count_s, out_count_w;
  logic signed [23:0] out_acc_d;
  logic signed [15:0] out_acc_s, out_acc_w;

  always #5 clk = ~clk;

  macc_accumulator dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_d),
    .out_ready(out_ready), .out_acc(out_acc_d), .out_ovf(out_ovf_d),
    .out_count(out_count_d)
  );

  macc_accumulator #(.PROD_W(15), .ACC_W(16), .SAT_EN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_acc(out_acc_s), .out_ovf(out_ovf_s),
    .out_count(out_count_s)
  );

  macc_accumulator #(.PROD_W(15), .ACC_W(16), .SAT_EN(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_acc(out_acc_w), .out_ovf(out_ovf_w),
    .out_count(out_count_w)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: beats of the open group and the result owed downstream.
  int     grp[$];
  bit     pending = 1'b0;
  longint e_acc[3];
  bit     e_ovf[3];
  int     e_cnt;
  int     cfg_w[3]   = '{24, 16, 16};
  bit     cfg_sat[3] = '{1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Sum of a group evaluated beat by beat with true integers, clamping or
  // wrapping whenever a running total leaves the w-bit signed range.
  function automatic void model(input int q[$], input int w, input bit sat,
                                output longint acc, output bit ovf);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    longint mn = -mx - 1;
    longint span = longint'(1) <<< w;
    longint s;
    acc = q[0];
    ovf = 1'b0;
    for (int i = 1; i < q.size(); i++) begin
      s = acc + q[i];
      if (s > mx || s < mn) begin
        ovf = 1'b1;
        if (sat) s = (s > mx) ? mx : mn;
        else     s = (s > mx) ? s - span : s + span;
      end
      acc = s;
    end
  endfunction

  task automatic chk_outs();
    chk("d.out_valid", out_valid_d, pending);
    chk("s.out_valid", out_valid_s, pending);
    chk("w.out_valid", out_valid_w, pending);
    if (pending) begin
      chk("d.out_acc", out_acc_d, e_acc[0]);
      chk("s.out_acc", out_acc_s, e_acc[1]);
      chk("w.out_acc", out_acc_w, e_acc[2]);
      chk("d.out_ovf", out_ovf_d, e_ovf[0]);
      chk("s.out_ovf", out_ovf_s, e_ovf[1]);
      chk("w.out_ovf", out_ovf_w, e_ovf[2]);
      chk("d.out_count", out_count_d, e_cnt);
      chk("s.out_count", out_count_s, e_cnt);
      chk("w.out_count", out_count_w, e_cnt);
    end
  endtask

  // One clock: offer (v,p,last) with the current out_ready, then check outputs.
  task automatic cycle(input bit v, input int p, input bit last, output bit took);
    bit rdy;
    in_valid = v;
    in_prod  = PW'(p);
    in_last  = last;
    #1;
    rdy = !pending || out_ready;
    chk("d.in_ready", in_ready_d, rdy);
    chk("s.in_ready", in_ready_s, rdy);
    chk("w.in_ready", in_ready_w, rdy);
    took = v && rdy;
    if (took) grp.push_back(p);
    @(posedge clk);
    #1;
    if (took) begin
      if (last) begin
        for (int k = 0; k < 3; k++) model(grp, cfg_w[k], cfg_sat[k], e_acc[k], e_ovf[k]);
        e_cnt = (grp.size() > 255) ? 255 : grp.size();
        grp.delete();
        pending = 1'b1;
      end else begin
        pending = 1'b0;
      end
    end else if (out_ready) begin
      pending = 1'b0;
    end
    chk_outs();
  endtask

  task automatic beat(input int p, input bit last);
    bit took;
    cycle(1'b1, p, last, took);
    chk("beat_taken", took, 1'b1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.in_ready",  in_ready_d,  1'b1);
    chk("rst.out_valid", out_valid_d, 1'b0);
    chk("rst.out_acc",   out_acc_d,   0);
    chk("rst.out_ovf",   out_ovf_d,   1'b0);
    chk("rst.out_count", out_count_d, 0);
    chk("rst.s.out_valid", out_valid_s, 1'b0);
    chk("rst.w.out_acc",   out_acc_w,   0);
    rst = 1'b0;
    grp.delete();
    pending = 1'b0;
  endtask

  initial begin
    bit took;
    int len, i, p;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Three-beat group
    beat(100, 1'b0); beat(-30, 1'b0); beat(5, 1'b1);
    chk("grp75.acc", out_acc_d, 75);
    chk("grp75.cnt", out_count_d, 3);
    cycle(1'b0, 0, 1'b0, took);

    // Accumulator limits
    beat(16383, 1'b0); beat(16383, 1'b0); beat(16383, 1'b1);
    chk("sat.s.acc", out_acc_s, 32767);
    chk("sat.w.acc", out_acc_w, -16387);
    chk("sat.w.ovf", out_ovf_w, 1'b1);
    beat(-16384, 1'b0); beat(-16384, 1'b0); beat(-16384, 1'b1);
    chk("satn.s.acc", out_acc_s, -32768);

    // Held result under backpressure, then a same-cycle hand-over
    beat(7, 1'b1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) cycle(1'b1, 3, 1'b1, took);
    chk("bp.acc_held", out_acc_d, 7);
    out_ready = 1'b1;
    beat(-8, 1'b1);
    chk("bp.next_acc", out_acc_d, -8);
    chk("bp.next_cnt", out_count_d, 1);
    cycle(1'b0, 0, 1'b0, took);

    // Back-to-back single-beat groups
    for (int k = 0; k < 256; k++) beat(1, 1'b1);
    cycle(1'b0, 0, 1'b0, took);

    // Beat count saturates while the sum continues
    for (int k = 0; k < 300; k++) beat(1, k == 299);
    chk("cnt.acc", out_acc_d, 300);
    chk("cnt.count", out_count_d, 255);
    cycle(1'b0, 0, 1'b0, took);

    // Reset discards a partial group
    beat(11, 1'b0); beat(22, 1'b0);
    do_reset();
    beat(9, 1'b1);
    chk("rst.next_acc", out_acc_d, 9);
    chk("rst.next_cnt", out_count_d, 1);

    // Reset while a result is held
    out_ready = 1'b0;
    cycle(1'b0, 0, 1'b0, took);
    do_reset();
    out_ready = 1'b1;
    cycle(1'b0, 0, 1'b0, took);

    // Random groups, gaps and backpressure
    for (int g = 0; g < 80; g++) begin
      len = $urandom_range(1, 6);
      i = 0;
      while (i < len) begin
        out_ready = ($urandom_range(0, 3) != 0);
        p = int'($urandom_range(0, 32767)) - 16384;
        cycle(($urandom_range(0, 3) != 0), p, (i == len - 1), took);
        if (took) i++;
      end
    end
    out_ready = 1'b1;
    cycle(1'b0, 0, 1'b0, took);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
